// File: rtl/spi_rategen_p.sv
// spi_rategen_p: SPI SCK/strobe generator (clk/nrst, en/start, div/nbits/cpol/cpha config in; clk_out/sampling/update/busy/done out)
module spi_rategen_p #(
  parameter int DIV_W  = 8,
  parameter int BITS_W = 5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              start,
  input  logic [DIV_W-1:0]  div,
  input  logic [BITS_W-1:0] nbits,
  input  logic              cpol,
  input  logic              cpha,
  output logic              clk_out,
  output logic              sampling,
  output logic              update,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;
  state_t state, state_n;
  logic [DIV_W-1:0] hcnt, hcnt_n, div_q;
  logic [BITS_W:0] ecnt, ecnt_n, last_e;
  logic [BITS_W-1:0] nbits_q;
  logic cpol_q, cpha_q, clk_n, smp_n, upd_n, done_n, hit, accept;
  assign last_e = {nbits_q, 1'b0};
  assign hit = hcnt == div_q;
  assign accept = state == IDLE && start && en;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    hcnt_n = hcnt;
    ecnt_n = ecnt;
    clk_n = clk_out;
    smp_n = 1'b0;
    upd_n = 1'b0;
    done_n = 1'b0;
    if (!en && state != IDLE) begin
      state_n = IDLE;
      hcnt_n = '0;
      ecnt_n = '0;
      clk_n = cpol_q;
    end else begin
      case (state)
        IDLE: begin
          clk_n = cpol;
          if (accept) begin
            hcnt_n = '0;
            ecnt_n = '0;
            state_n = nbits == '0 ? IDLE : RUN;
            done_n = nbits == '0;
            upd_n = nbits != '0 && !cpha;
          end
        end
        RUN: begin
          hcnt_n = hit ? '0 : hcnt + 1'b1;
          if (hit) begin
            ecnt_n = ecnt + 1'b1;
            clk_n = !clk_out;
            smp_n = ecnt_n[0] ^ cpha_q;
            upd_n = !smp_n && ecnt_n != last_e;
            state_n = ecnt_n == last_e ? TAIL : RUN;
          end
        end
        TAIL: begin
          clk_n = cpol_q;
          hcnt_n = hit ? '0 : hcnt + 1'b1;
          state_n = hit ? IDLE : TAIL;
          done_n = hit;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      hcnt <= '0;
      ecnt <= '0;
      clk_out <= 1'b0;
      sampling <= 1'b0;
      update <= 1'b0;
      done <= 1'b0;
      div_q <= '0;
      nbits_q <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else begin
      state <= state_n;
      hcnt <= hcnt_n;
      ecnt <= ecnt_n;
      clk_out <= clk_n;
      sampling <= smp_n;
      update <= upd_n;
      done <= done_n;
      if (accept) begin
        div_q <= div;
        nbits_q <= nbits;
        cpol_q <= cpol;
        cpha_q <= cpha;
      end
    end
  end
endmodule

// File: tb/tb_spi_rategen_p.sv
// tb_spi_rategen_p: scoreboard bench comparing spi_rategen_p against an arithmetic transfer-schedule model
module tb_spi_rategen_p;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic en = 1'b0;
  logic start = 1'b0;
  logic [7:0] div = '0;
  logic [4:0] nbits = '0;
  logic cpol = 1'b0;
  logic cpha = 1'b0;
  logic clk_out, sampling, update, busy, done;
  int tests = 0;
  int fails = 0;
  logic [4:0] q[$];
  bit act = 0;
  int k, per, len, j, ed, nb_q;
  logic cp_q, ph_q, s, u, lead;
  logic [4:0] e;
  logic [4:0] got, ex;
  spi_rategen_p dut (
    .clk(clk), .nrst(nrst), .en(en), .start(start), .div(div), .nbits(nbits),
    .cpol(cpol), .cpha(cpha), .clk_out(clk_out), .sampling(sampling),
    .update(update), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    if (!nrst) begin
      act = 0;
      e = '0;
    end else if (act && !en) begin
      act = 0;
      e = {cp_q, 4'b0000};
    end else if (act) begin
      k++;
      if (k == len) begin
        act = 0;
        e = {cp_q, 4'b0001};
      end else begin
        j = k / per;
        ed = j > 2 * nb_q ? 2 * nb_q : j;
        s = 1'b0;
        u = 1'b0;
        if (k % per == 0 && j >= 1 && j <= 2 * nb_q) begin
          lead = (j % 2) != 0;
          s = ph_q ? !lead : lead;
          u = !s && j != 2 * nb_q;
        end
        e = {cp_q ^ ((ed % 2) != 0), s, u, 1'b1, 1'b0};
      end
    end else if (en && start) begin
      per = int'(div) + 1;
      nb_q = int'(nbits);
      cp_q = cpol;
      ph_q = cpha;
      len = (2 * nb_q + 1) * per;
      k = 0;
      if (nb_q == 0) e = {cpol, 4'b0001};
      else begin
        act = 1;
        e = {cpol, 1'b0, !cpha, 1'b1, 1'b0};
      end
    end else e = {cpol, 4'b0000};
    q.push_back(e);
  end
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      ex = q.pop_front();
      got = {clk_out, sampling, update, busy, done};
      tests++;
      if (got !== ex) begin
        fails++;
        $display("FAIL outputs t=%0t {clk_out,sampling,update,busy,done} got %b expected %b", $time, got, ex);
      end
      tests++;
      if (sampling && update) begin
        fails++;
        $display("FAIL strobe_excl t=%0t sampling=%b update=%b expected not both high", $time, sampling, update);
      end
    end
  end
  task automatic drv(input logic r, input logic en_i, input logic st, input logic [7:0] d,
                     input logic [4:0] nb, input logic cp, input logic ph);
    @(negedge clk);
    nrst = r;
    en = en_i;
    start = st;
    div = d;
    nbits = nb;
    cpol = cp;
    cpha = ph;
  endtask
  task automatic idle(input int c);
    repeat (c) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask
  initial begin
    drv(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    drv(1, 1, 0, 0, 0, 0, 0);
    idle(1);
    drv(1, 1, 1, 0, 2, 0, 0);
    idle(5);
    drv(1, 1, 1, 0, 2, 0, 0);
    idle(8);
    drv(1, 1, 1, 3, 1, 1, 1);
    idle(15);
    drv(1, 1, 1, 3, 1, 1, 1);
    idle(5);
    drv(1, 0, 0, 3, 1, 1, 1);
    drv(1, 1, 0, 3, 1, 1, 1);
    idle(14);
    drv(1, 1, 1, 5, 0, 1, 0);
    idle(4);
    drv(1, 1, 1, 0, 2, 0, 0);
    idle(2);
    drv(0, 1, 0, 0, 2, 0, 0);
    drv(1, 1, 0, 0, 2, 0, 0);
    idle(6);
    drv(1, 0, 1, 1, 3, 0, 0);
    idle(3);
    for (int i = 0; i < 4000; i++)
      drv($urandom_range(0, 299) != 0, $urandom_range(0, 59) != 0, $urandom_range(0, 3) == 0,
          8'($urandom_range(0, 4)), $urandom_range(0, 9) == 0 ? 5'd31 : 5'($urandom_range(0, 4)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
